// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - size encodings and FSM state type for the load/store unit
package mem_access_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane shifter, byte-enable generator and load sign-extender
module lsu_align
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LSB   = 2
) (
  input  logic [1:0]              size,
  input  logic [ADDR_LSB-1:0]     offset,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   rdata_lo,
  input  logic [DATA_WIDTH-1:0]   rdata_hi,
  output logic                    split,
  output logic [DATA_WIDTH/8-1:0] be_lo,
  output logic [DATA_WIDTH/8-1:0] be_hi,
  output logic [DATA_WIDTH-1:0]   wdata_lo,
  output logic [DATA_WIDTH-1:0]   wdata_hi,
  output logic [DATA_WIDTH-1:0]   load_data
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int MW   = 2 * BE_W;
  localparam int SW   = ADDR_LSB + 3;

  logic [MW-1:0]           mask;
  logic [MW-1:0]           mask_sh;
  logic [SW-1:0]           bit_shift;
  logic [2*DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0]   rdata_sh;

  always_comb begin
    mask = '0;
    case (size)
      SZ_WORD: mask = {{BE_W{1'b0}}, {BE_W{1'b1}}};
      SZ_HALF: mask = MW'(3);
      SZ_BYTE: mask = MW'(1);
      default: mask = '0;
    endcase
  end

  assign bit_shift = {offset, 3'b000};
  assign mask_sh   = mask << offset;
  assign be_lo     = mask_sh[BE_W-1:0];
  assign be_hi     = mask_sh[MW-1:BE_W];
  // any lane pushed past the word boundary means a second beat is needed
  assign split     = |be_hi;

  assign wdata_sh  = {{DATA_WIDTH{1'b0}}, wdata} << bit_shift;
  assign wdata_lo  = wdata_sh[DATA_WIDTH-1:0];
  assign wdata_hi  = wdata_sh[2*DATA_WIDTH-1:DATA_WIDTH];

  assign rdata_sh  = DATA_WIDTH'({rdata_hi, rdata_lo} >> bit_shift);

  always_comb begin
    load_data = rdata_sh;
    case (size)
      SZ_BYTE: load_data = {{(DATA_WIDTH-8){rdata_sh[7]}}, rdata_sh[7:0]};
      SZ_HALF: load_data = {{(DATA_WIDTH-16){rdata_sh[15]}}, rdata_sh[15:0]};
      default: load_data = rdata_sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit splitting misaligned accesses into two word beats
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LSB   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [1:0]              load_size_i,
  input  logic [1:0]              store_size_i,
  output logic                    stall_o,
  output logic                    done_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ack_i
);

  state_t                  state;
  logic [ADDR_LSB-1:0]     off_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_lo_q;
  logic [1:0]              size_q;
  logic                    store_q;

  logic                    idle;
  logic                    start;
  logic [1:0]              req_size;
  logic [1:0]              op_size;
  logic [ADDR_LSB-1:0]     op_offset;
  logic [DATA_WIDTH-1:0]   op_wdata;
  logic [DATA_WIDTH-1:0]   rd_lo;
  logic [DATA_WIDTH-1:0]   rd_hi;
  logic                    split;
  logic [DATA_WIDTH/8-1:0] be_lo;
  logic [DATA_WIDTH/8-1:0] be_hi;
  logic [DATA_WIDTH-1:0]   wdata_lo;
  logic [DATA_WIDTH-1:0]   wdata_hi;
  logic [DATA_WIDTH-1:0]   load_data;

  assign idle     = (state == ST_IDLE);
  assign start    = idle && ((load_size_i != SZ_NONE) || (store_size_i != SZ_NONE));
  // a store wins when both sizes are presented together
  assign req_size = (store_size_i != SZ_NONE) ? store_size_i : load_size_i;

  // the aligner sees live operands at the start edge and captured ones afterwards
  assign op_size   = idle ? req_size : size_q;
  assign op_offset = idle ? addr_i[ADDR_LSB-1:0] : off_q;
  assign op_wdata  = idle ? wdata_i : wdata_q;
  assign rd_lo     = (state == ST_BEAT2) ? rdata_lo_q : mem_rdata_i;
  assign rd_hi     = (state == ST_BEAT2) ? mem_rdata_i : '0;

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_LSB   (ADDR_LSB)
  ) u_align (
    .size      (op_size),
    .offset    (op_offset),
    .wdata     (op_wdata),
    .rdata_lo  (rd_lo),
    .rdata_hi  (rd_hi),
    .split     (split),
    .be_lo     (be_lo),
    .be_hi     (be_hi),
    .wdata_lo  (wdata_lo),
    .wdata_hi  (wdata_hi),
    .load_data (load_data)
  );

  assign mem_req_o = (state == ST_BEAT1) || (state == ST_BEAT2);
  assign done_o    = (state == ST_DONE);
  assign stall_o   = rst_n && (start || mem_req_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      off_q       <= '0;
      wdata_q     <= '0;
      rdata_lo_q  <= '0;
      size_q      <= SZ_NONE;
      store_q     <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            off_q       <= addr_i[ADDR_LSB-1:0];
            wdata_q     <= wdata_i;
            size_q      <= req_size;
            store_q     <= (store_size_i != SZ_NONE);
            mem_we_o    <= (store_size_i != SZ_NONE);
            mem_addr_o  <= {addr_i[DATA_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
            mem_be_o    <= be_lo;
            mem_wdata_o <= wdata_lo;
            state       <= ST_BEAT1;
          end
        end
        ST_BEAT1: begin
          if (mem_ack_i) begin
            if (split) begin
              rdata_lo_q  <= mem_rdata_i;
              mem_addr_o  <= mem_addr_o + DATA_WIDTH'(1 << ADDR_LSB);
              mem_be_o    <= be_hi;
              mem_wdata_o <= wdata_hi;
              state       <= ST_BEAT2;
            end else begin
              if (!store_q) rdata_o <= load_data;
              mem_we_o    <= 1'b0;
              mem_be_o    <= '0;
              mem_wdata_o <= '0;
              state       <= ST_DONE;
            end
          end
        end
        ST_BEAT2: begin
          if (mem_ack_i) begin
            if (!store_q) rdata_o <= load_data;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            state       <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table-driven bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [1:0]  load_size_i = 2'b00;
  logic [1:0]  store_size_i = 2'b00;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rdata = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_LSB(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .load_size_i  (load_size_i),
    .store_size_i (store_size_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  ld;
    logic [1:0]  st;
    int          delay;
    logic [31:0] lo;
    logic [31:0] hi;
    int          nb;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] w1;
    logic [31:0] a2;
    logic [3:0]  be2;
    logic [31:0] w2;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int waitc, nb, reqc, lat;
    logic stall_ok, done_stall;
    logic [31:0] base;
    logic [31:0] ra[2];
    logic [3:0]  rb[2];
    logic [31:0] rw[2];
    logic        rwe[2];
    waitc = 0; nb = 0; reqc = 0; lat = -1; stall_ok = 1'b1; done_stall = 1'b1;
    base = {v.addr[31:2], 2'b00};
    for (int i = 0; i < 2; i++) begin ra[i] = 'x; rb[i] = 'x; rw[i] = 'x; rwe[i] = 1'bx; end
    @(negedge clk);
    addr_i = v.addr; wdata_i = v.wdata; load_size_i = v.ld; store_size_i = v.st;
    #1 chk({tag, " stall_at_start"}, {31'b0, stall_o}, 32'd1);
    @(posedge clk);
    #1 addr_i = '0; wdata_i = '0; load_size_i = 2'b00; store_size_i = 2'b00;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      if (done_o) begin
        lat = c;
        done_stall = stall_o;
        break;
      end
      if (mem_req_o) begin
        reqc++;
        if (!stall_o) stall_ok = 1'b0;
        if (waitc == 0 && nb < 2) begin
          ra[nb] = mem_addr_o; rb[nb] = mem_be_o; rw[nb] = mem_wdata_o; rwe[nb] = mem_we_o;
        end
        if (waitc == v.delay) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = (mem_addr_o == base) ? v.lo : v.hi;
          nb++;
          waitc = 0;
        end else begin
          waitc++;
        end
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " beats"}, 32'(nb), 32'(v.nb));
    chk({tag, " req_cycles"}, 32'(reqc), 32'(v.nb * (v.delay + 1)));
    chk({tag, " stall_during_req"}, {31'b0, stall_ok}, 32'd1);
    chk({tag, " stall_in_done"}, {31'b0, done_stall}, 32'd0);
    chk({tag, " addr1"}, ra[0], v.a1);
    chk({tag, " be1"}, {28'b0, rb[0]}, {28'b0, v.be1});
    chk({tag, " we1"}, {31'b0, rwe[0]}, {31'b0, (v.st != 2'b00)});
    if (v.st != 2'b00) chk({tag, " wdata1"}, rw[0], v.w1);
    if (v.nb == 2) begin
      chk({tag, " addr2"}, ra[1], v.a2);
      chk({tag, " be2"}, {28'b0, rb[1]}, {28'b0, v.be2});
      if (v.st != 2'b00) chk({tag, " wdata2"}, rw[1], v.w2);
    end
    if (v.st == 2'b00) last_rdata = v.rd;
    chk({tag, " rdata"}, rdata_o, last_rdata);
    @(negedge clk);
    chk({tag, " done_pulse_width"}, {31'b0, done_o}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h100, 32'hDEADBEEF, 2'b00, 2'b01, 0, 32'h0, 32'h0, 1,
                32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0, 32'h0, 2};
    vecs[1] = '{32'h203, 32'h0, 2'b11, 2'b00, 0, 32'h80FF0000, 32'h0, 1,
                32'h200, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80, 2};
    vecs[2] = '{32'h102, 32'h0, 2'b01, 2'b00, 0, 32'h44332211, 32'h88776655, 2,
                32'h100, 4'hC, 32'h0, 32'h104, 4'h3, 32'h0, 32'h66554433, 3};
    vecs[3] = '{32'hFFFFFFFF, 32'h0000ABCD, 2'b00, 2'b10, 0, 32'h0, 32'h0, 2,
                32'hFFFFFFFC, 4'h8, 32'hCD000000, 32'h0, 4'h1, 32'h000000AB, 32'h0, 3};
    vecs[4] = '{32'h300, 32'h12345678, 2'b11, 2'b01, 3, 32'h0, 32'h0, 1,
                32'h300, 4'hF, 32'h12345678, 32'h0, 4'h0, 32'h0, 32'h0, 5};
    vecs[5] = '{32'h102, 32'h0, 2'b10, 2'b00, 0, 32'h80001234, 32'h0, 1,
                32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF8000, 2};
    vecs[6] = '{32'h101, 32'hAABBCC5A, 2'b00, 2'b11, 1, 32'h0, 32'h0, 1,
                32'h100, 4'h2, 32'hBBCC5A00, 32'h0, 4'h0, 32'h0, 32'h0, 3};
    vecs[7] = '{32'h103, 32'h0, 2'b10, 2'b00, 0, 32'h34000000, 32'h00000012, 2,
                32'h100, 4'h8, 32'h0, 32'h104, 4'h1, 32'h0, 32'h00001234, 3};
    vecs[8] = '{32'h0, 32'h0, 2'b01, 2'b00, 2, 32'hCAFEF00D, 32'h0, 1,
                32'h0, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D, 4};
    vecs[9] = '{32'h101, 32'h11223344, 2'b00, 2'b01, 0, 32'h0, 32'h0, 2,
                32'h100, 4'hE, 32'h22334400, 32'h104, 4'h1, 32'h00000011, 32'h0, 3};

    #1;
    chk("reset mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("reset done", {31'b0, done_o}, 32'd0);
    chk("reset stall", {31'b0, stall_o}, 32'd0);
    chk("reset we", {31'b0, mem_we_o}, 32'd0);
    chk("reset be", {28'b0, mem_be_o}, 32'd0);
    chk("reset addr", mem_addr_o, 32'd0);
    chk("reset wdata", mem_wdata_o, 32'd0);
    chk("reset rdata", rdata_o, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    @(negedge clk) mem_ack_i = 1'b1;
    @(negedge clk) mem_ack_i = 1'b0;
    #1 chk("idle ack ignored req", {31'b0, mem_req_o}, 32'd0);
    chk("idle ack ignored done", {31'b0, done_o}, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abandon a split load while its second beat is outstanding
    @(negedge clk);
    addr_i = 32'h102; load_size_i = 2'b01;
    @(posedge clk);
    #1 addr_i = '0; load_size_i = 2'b00;
    @(negedge clk);
    chk("rst seq beat1 req", {31'b0, mem_req_o}, 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h44332211;
    @(negedge clk);
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    chk("rst seq beat2 addr", mem_addr_o, 32'h104);
    rst_n = 1'b0;
    #1;
    chk("rst seq req", {31'b0, mem_req_o}, 32'd0);
    chk("rst seq stall", {31'b0, stall_o}, 32'd0);
    chk("rst seq done", {31'b0, done_o}, 32'd0);
    chk("rst seq be", {28'b0, mem_be_o}, 32'd0);
    chk("rst seq addr", mem_addr_o, 32'd0);
    chk("rst seq rdata", rdata_o, 32'd0);
    last_rdata = '0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst seq no done", {31'b0, done_o}, 32'd0);
      chk("rst seq no retry", {31'b0, mem_req_o}, 32'd0);
    end
    run_vec(vecs[2], "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
